// File: rtl/imem_loader_pkg.sv
// Shared types and sizing constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int MEM_BYTES = 32;
  localparam int MAX_WORDS = MEM_BYTES / 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Running XOR checksum over the data bytes of a program image.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and core status of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wd;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wd, cpu_hold, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wd, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// while holding the core stalled until a good image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = imem_loader_pkg::MEM_BYTES,
  parameter int ADDR_W    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  localparam int         CNT_W       = ADDR_W + 1;
  localparam logic [7:0] MAX_WORDS_B = 8'(MEM_BYTES / 4);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [7:0]        acc_q, acc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wd_q, wd_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_s;
  logic              accept_s;

  // A start pulse wins over any byte offered in the same cycle.
  assign ready_s  = (state_q inside {ST_LEN, ST_DATA, ST_CSUM}) && !bus.start;
  assign accept_s = ready_s && bus.byte_valid;

  // Next-state, counter, checksum and write-port logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;

    if (bus.start) begin
      state_d = ST_LEN;
      cnt_d   = '0;
      total_d = '0;
      acc_d   = 8'h00;
    end else if (accept_s) begin
      case (state_q)
        ST_LEN: begin
          if ((bus.byte_data == 8'h00) || (bus.byte_data > MAX_WORDS_B)) begin
            state_d = ST_ERR;
          end else begin
            total_d = CNT_W'({bus.byte_data, 2'b00});
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          acc_d  = csum_step(acc_q, bus.byte_data);
          cnt_d  = cnt_q + CNT_W'(1);
          we_d   = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          wd_d   = bus.byte_data;
          if (cnt_d == total_q) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_CSUM: begin
          if (bus.byte_data == acc_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
    hold_d = !done_d;
  end

  // State and output registers; reset also drops any write still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      total_q <= '0;
      acc_q   <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= 8'h00;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready = ready_s;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wd     = wd_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level reference model checked every
// cycle, plus literal expectations for the documented load scenarios.
module tb_imem_loader;

  localparam int MAXW = 32 / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(5)) bus ();

  imem_loader #(.MEM_BYTES(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: position in the stream since the last start.
  bit       m_loading = 1'b0;
  int       m_pos     = 0;
  int       m_n       = 0;
  bit [7:0] m_x       = 8'h00;
  int       m_verdict = 0;       // 0 none, 1 good, 2 bad
  bit       exp_we    = 1'b0;
  int       exp_addr  = 0;
  int       exp_wd    = 0;
  bit       exp_ready = 1'b0;
  int       m_wr_count = 0;
  int       m_first_addr = -1;
  int       m_first_data = -1;
  int       m_last_addr  = -1;
  int       m_last_data  = -1;
  int       m_max_addr   = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0; m_pos = 0; m_n = 0; m_x = 8'h00; m_verdict = 0;
    exp_we = 1'b0; exp_addr = 0; exp_wd = 0; exp_ready = 1'b0;
    m_wr_count = 0; m_first_addr = -1; m_first_data = -1;
    m_last_addr = -1; m_last_data = -1; m_max_addr = -1;
  endtask

  task automatic model_update(input bit s, input bit v, input bit [7:0] d);
    exp_we = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (s) begin
      m_loading = 1'b1; m_pos = 0; m_x = 8'h00; m_verdict = 0;
      m_wr_count = 0; m_first_addr = -1; m_first_data = -1;
    end else if (m_loading && v) begin
      if (m_pos == 0) begin
        if (d == 8'h00 || int'(d) > MAXW) begin
          m_loading = 1'b0; m_verdict = 2;
        end else begin
          m_n = int'(d); m_pos = 1;
        end
      end else if (m_pos <= 4 * m_n) begin
        exp_we = 1'b1; exp_addr = m_pos - 1; exp_wd = int'(d);
        m_x = m_x ^ d;
        if (m_wr_count == 0) begin
          m_first_addr = exp_addr; m_first_data = exp_wd;
        end
        m_wr_count++;
        m_last_addr = exp_addr; m_last_data = exp_wd;
        if (exp_addr > m_max_addr) m_max_addr = exp_addr;
        m_pos++;
      end else begin
        m_loading = 1'b0;
        m_verdict = (d == m_x) ? 1 : 2;
      end
    end
  endtask

  // One clock cycle of stimulus: drive, let the edge pass, advance the model.
  task automatic cyc(input bit s, input bit v, input bit [7:0] d);
    bus.start = s; bus.byte_valid = v; bus.byte_data = d;
    exp_ready = m_loading && !s && rst_n;
    @(posedge clk);
    #1;
    model_update(s, v, d);
  endtask

  task automatic send(input bit [7:0] bytes[$]);
    foreach (bytes[i]) cyc(1'b0, 1'b1, bytes[i]);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("byte_ready", 32'(bus.byte_ready), 32'(exp_ready));
    chk("mem_we",     32'(bus.mem_we),     32'(exp_we));
    chk("mem_addr",   32'(bus.mem_addr),   32'(exp_addr));
    chk("mem_wd",     32'(bus.mem_wd),     32'(exp_wd));
    chk("cpu_hold",   32'(bus.cpu_hold),   32'(m_verdict != 1));
    chk("done",       32'(bus.done),       32'(m_verdict == 1));
    chk("error",      32'(bus.error),      32'(m_verdict == 2));
  end

  initial begin
    bit [7:0] img[$];
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold",  32'(bus.cpu_hold),   32'd1);
    chk("rst_we",    32'(bus.mem_we),     32'd0);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    rst_n = 1'b1;

    // Bytes offered before any start are ignored.
    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h20);

    // N=1 image with a valid gap mid-stream.
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h20);
    cyc(1'b0, 1'b0, 8'hFF);
    send('{8'h02, 8'h00, 8'h0A, 8'h28});
    cyc(1'b0, 1'b0, 8'h00);
    chk("t1_done",   32'(bus.done),     32'd1);
    chk("t1_hold",   32'(bus.cpu_hold), 32'd0);
    chk("t1_writes", 32'(m_wr_count),   32'd4);
    chk("t1_first",  32'(m_first_data), 32'h20);
    chk("t1_last",   32'(m_last_data),  32'h0A);
    chk("t1_laddr",  32'(m_last_addr),  32'd3);

    // Full-size image, N=8, bytes 0x00..0x1F.
    cyc(1'b1, 1'b0, 8'h00);
    img = {};
    img.push_back(8'h08);
    for (int i = 0; i < 32; i++) img.push_back(8'(i));
    img.push_back(8'h00);
    send(img);
    cyc(1'b0, 1'b0, 8'h00);
    chk("t2_done",   32'(bus.done),     32'd1);
    chk("t2_writes", 32'(m_wr_count),   32'd32);
    chk("t2_laddr",  32'(m_last_addr),  32'd31);
    chk("t2_ldata",  32'(m_last_data),  32'h1F);
    chk("t2_maxadr", 32'(m_max_addr),   32'd31);
    chk("t2_dutadr", 32'(bus.mem_addr), 32'd31);

    // Bad lengths 0x00 and 0x09.
    cyc(1'b1, 1'b0, 8'h00);
    send('{8'h00, 8'h20, 8'h02});
    chk("t3a_err",   32'(bus.error),      32'd1);
    chk("t3a_ready", 32'(bus.byte_ready), 32'd0);
    chk("t3a_hold",  32'(bus.cpu_hold),   32'd1);
    chk("t3a_wr",    32'(m_wr_count),     32'd0);
    cyc(1'b1, 1'b0, 8'h00);
    send('{8'h09, 8'h20, 8'h02});
    chk("t3b_err",   32'(bus.error),      32'd1);
    chk("t3b_ready", 32'(bus.byte_ready), 32'd0);
    chk("t3b_wr",    32'(m_wr_count),     32'd0);

    // Bad checksum.
    cyc(1'b1, 1'b0, 8'h00);
    send('{8'h01, 8'h20, 8'h02, 8'h00, 8'h0A, 8'h29});
    cyc(1'b0, 1'b0, 8'h00);
    chk("t4_wr",   32'(m_wr_count),   32'd4);
    chk("t4_err",  32'(bus.error),    32'd1);
    chk("t4_done", 32'(bus.done),     32'd0);
    chk("t4_hold", 32'(bus.cpu_hold), 32'd1);

    // N=2 with gaps; restart coincident with a valid byte after the 3rd data byte.
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h02);
    cyc(1'b0, 1'b1, 8'hD0);
    cyc(1'b0, 1'b0, 8'hEE);
    cyc(1'b0, 1'b1, 8'hD1);
    cyc(1'b0, 1'b0, 8'hEE);
    cyc(1'b0, 1'b0, 8'hEE);
    cyc(1'b0, 1'b1, 8'hD2);
    cyc(1'b1, 1'b1, 8'hAA);
    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b0, 8'h77);
    send('{8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
    cyc(1'b0, 1'b0, 8'h00);
    chk("t5_faddr", 32'(m_first_addr), 32'd0);
    chk("t5_fdata", 32'(m_first_data), 32'h11);
    chk("t5_wr",    32'(m_wr_count),   32'd4);
    chk("t5_done",  32'(bus.done),     32'd1);

    // Reset asserted right after the 2nd data byte is accepted.
    cyc(1'b1, 1'b0, 8'h00);
    send('{8'h02, 8'h5A, 8'hA5});
    rst_n = 1'b0;
    #1;
    chk("t6_we",    32'(bus.mem_we),     32'd0);
    chk("t6_ready", 32'(bus.byte_ready), 32'd0);
    chk("t6_hold",  32'(bus.cpu_hold),   32'd1);
    chk("t6_addr",  32'(bus.mem_addr),   32'd0);
    chk("t6_wd",    32'(bus.mem_wd),     32'd0);
    model_reset();
    send('{8'h3C, 8'h3D, 8'h3E});
    rst_n = 1'b1;
    send('{8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
    chk("t6_idle_hold", 32'(bus.cpu_hold), 32'd1);
    chk("t6_idle_done", 32'(bus.done),     32'd0);
    chk("t6_idle_err",  32'(bus.error),    32'd0);
    chk("t6_idle_wr",   32'(m_wr_count),   32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: MEM_BYTES, default 32, instruction-memory size in bytes (byte-addressed).
REQ-002 Parameter: ADDR_W, default 5, memory byte-address width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  one-cycle pulse that begins or restarts a program load.
REQ-006 Port: byte_valid  input  1  host byte-stream valid.
REQ-007 Port: byte_data  input  8  host byte-stream data.
REQ-008 Port: byte_ready  output  1  loader can accept a byte; transfer occurs on byte_valid && byte_ready.
REQ-009 Port: mem_we  output  1  instruction-memory byte write enable.
REQ-010 Port: mem_addr  output  ADDR_W  instruction-memory byte address.
REQ-011 Port: mem_wd  output  8  instruction-memory byte write data.
REQ-012 Port: cpu_hold  output  1  high holds the core (PC) stalled.
REQ-013 Port: done  output  1  load completed with a good checksum.
REQ-014 Port: error  output  1  load aborted because of a bad length or a bad checksum.

Function
REQ-015 States: IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-016 Stream format: one length byte N (word count), then 4*N data bytes, then one checksum byte.
- Checksum = XOR of all data bytes.
REQ-017 byte_ready is 1 in LEN, DATA and CSUM, and 0 in every other state.
- byte_ready is forced to 0 in any cycle where start=1.
REQ-018 start in any state goes to LEN next cycle.
- Clears the byte counter, write address and checksum accumulator.
- Clears done and error.
- Sets cpu_hold=1.
REQ-019 start has priority over a simultaneous byte; that byte is not accepted.
REQ-020 LEN, on accept:
- N=0 or N>MEM_BYTES/4 -> ERR.
- Otherwise store N and go to DATA.
REQ-021 DATA, on each accept: XOR the byte into the accumulator and increment the byte counter.
- After byte 4*N is accepted -> CSUM.
REQ-022 Each accepted DATA byte produces exactly one mem_we pulse in the following cycle.
- mem_addr is 0 for the first byte and increments by 1 per byte.
- mem_wd equals the accepted byte.
- Fixed 1-cycle latency.
REQ-023 Byte k (0-based) is written to address k.
- The maximum address is MEM_BYTES-1; no wrap is possible because of REQ-020.
REQ-024 mem_we=0 in every cycle without a write; mem_addr and mem_wd hold their last values.
REQ-025 CSUM, on accept:
- byte equals accumulator -> DONE.
- Otherwise -> ERR.
REQ-026 DONE: done=1, cpu_hold=0, error=0; held until the next start or reset.
REQ-027 ERR: error=1, cpu_hold=1, done=0; held until the next start or reset.
REQ-028 IDLE: cpu_hold=1, done=0, error=0.
REQ-029 Gaps in byte_valid stall the loader indefinitely with no timeout; state and counters are held.
REQ-030 Bytes presented while byte_ready=0 are ignored.
- No memory write.
- No change to the accumulator.

Reset
REQ-031 rst_n=0 asynchronously forces:
- state IDLE.
- cpu_hold=1, done=0, error=0.
- mem_we=0, mem_addr=0, mem_wd=0, byte_ready=0.
- Counters and accumulator cleared.
REQ-032 Reset asserted mid-load aborts the load immediately.
- No further mem_we pulses.
- A write pending from the cycle before reset is dropped.
REQ-033 After rst_n deasserts, the loader stays in IDLE until start.

Structure
REQ-034 Package imem_loader_pkg holds:
- the state enum.
- the constants MEM_BYTES=32 and MAX_WORDS=MEM_BYTES/4.
REQ-035 Single module with no sub-module; the checksum accumulator and counters are inline registers.

Verification
REQ-036 Reset, start, stream 01 20 02 00 0A 28 (N=1, checksum 0x28) ->
- mem_we pulses at addr 0..3 with data 20, 02, 00, 0A.
- done=1, cpu_hold=0.
REQ-037 N=8 with 32 bytes 0x00..0x1F, checksum 0x00 ->
- last write addr 31 data 0x1F.
- done=1.
- No write at any address beyond 31.
REQ-038 Length byte 0x00, and separately 0x09 ->
- error=1, byte_ready=0, cpu_hold=1.
- No mem_we.
REQ-039 N=1, bytes 20 02 00 0A, checksum 0x29 ->
- 4 writes occur.
- error=1, done=0, cpu_hold=1.
REQ-040 N=2 with byte_valid toggled randomly, start pulsed after the 3rd data byte, start and byte_valid coincident ->
- the coincident byte is not accepted.
- Restart expects the length byte next; the next write is at addr 0.
REQ-041 rst_n pulled low after the 2nd data byte ->
- Outputs take reset values immediately.
- No further writes.
- IDLE is held until start.
